// File: rtl/bus_master_pipe_pkg.sv
// Shared bus types and defaults for the pipelined bus master and its slaves.
package bus;

  localparam int MAX_OUT_DEF = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 30;
  localparam int SEL_W       = 4;
  localparam int TO_W        = 8;

  typedef struct packed {
    logic              ack;
    logic              err;
    logic              stall;
    logic [DATA_W-1:0] data;
  } s2m_s;

  typedef struct packed {
    logic              cyc;
    logic              stb;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } m2s_s;

endpackage

// File: rtl/bus_master_pipe_track_fifo.sv
// Tracks the direction (1=write) of each outstanding request, oldest at the head.
module bus_track_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  input  logic flush_i,
  output logic head_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_q, rd_q;

  // Pointers wrap naturally because DEPTH is a power of two; occupancy lives in the parent.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o = mem_q[rd_q];

endmodule

// File: rtl/bus_master_pipe.sv
// Pipelined bus master: issues client requests, tracks up to MAX_OUT in flight, completes in order.
// Optional abort of stuck transfers with BUS_MASTER_TIMEOUT_EN.
module bus_master_pipe
  import bus::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  input  logic [29:0] addr_i,
  input  logic [3:0]  byte_mask_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        wack_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        busy_o,
  input  s2m_s        bus_i,
  output m2s_s        bus_o
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic full, nonempty, accept, ack_ok, flush, spurious, head_we, timeout_hit;

  assign full     = (count_q == CNT_W'(MAX_OUT));
  assign nonempty = (count_q != '0);

  always_comb begin
    bus_o      = '0;
    bus_o.stb  = en_i & ~full & ~rst;
    bus_o.we   = bus_o.stb & we_i;
    bus_o.cyc  = (bus_o.stb | nonempty) & ~rst;
    bus_o.sel  = byte_mask_i;
    bus_o.addr = addr_i;
    bus_o.data = data_i;
  end

  assign stall_o  = rst | full | bus_i.stall | bus_i.err | timeout_hit;
  assign accept   = en_i & ~stall_o;
  assign ack_ok   = bus_i.ack & ~bus_i.err & nonempty & ~timeout_hit & ~rst;
  assign flush    = (bus_i.err & nonempty) | timeout_hit;
  assign spurious = (bus_i.ack | bus_i.err) & ~nonempty;

  assign valid_o = ack_ok & ~head_we;
  assign wack_o  = ack_ok & head_we;
  assign err_o   = (spurious | flush) & ~rst;
  assign busy_o  = nonempty;
  assign data_o  = bus_i.data;

  // Accept is blocked by stall_o on any flush cycle, so flush never races a push.
  always_comb begin
    count_d = count_q;
    if (flush)                count_d = '0;
    else if (accept & ~ack_ok) count_d = count_q + CNT_W'(1);
    else if (ack_ok & ~accept) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  bus_track_fifo #(.DEPTH(MAX_OUT)) u_track (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .din_i   (we_i),
    .pop_i   (ack_ok),
    .flush_i (flush),
    .head_o  (head_we)
  );

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;

  // Any slave response counts as progress, so an ack on the terminal cycle wins over the abort.
  always_comb begin
    to_d = to_q + TO_W'(1);
    if (~nonempty | bus_i.ack | bus_i.err) to_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end

  assign timeout_hit = nonempty & ~bus_i.ack & ~bus_i.err & (to_q == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_pipe.sv
// Scoreboard bench for bus_master_pipe: in-order completion, backpressure, error flush, reset discard.
module tb_bus_master_pipe;
  import bus::*;

  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i, we_i;
  logic [31:0] data_i;
  logic [29:0] addr_i;
  logic [3:0]  byte_mask_i;
  logic [31:0] data_o;
  logic        valid_o, wack_o, stall_o, err_o, busy_o;
  s2m_s        bus_i;
  m2s_s        bus_o;

  always #5 clk = ~clk;

  bus_master_pipe #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .we_i(we_i), .data_i(data_i), .addr_i(addr_i),
    .byte_mask_i(byte_mask_i), .data_o(data_o), .valid_o(valid_o), .wack_o(wack_o),
    .stall_o(stall_o), .err_o(err_o), .busy_o(busy_o), .bus_i(bus_i), .bus_o(bus_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ack_pend[$];
  bit          cpl_log[$];
  bit          auto_ack;
  logic        man_ack, man_err;
  logic        last_acc;
  logic        s_err, s_valid, s_wack, s_stall, s_cyc, s_stb, s_busy;
  int          n_valid, n_stall;

  function automatic logic [31:0] slave_data(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // One bus cycle: drive slave, sample mid-cycle, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    bus_i.stall = 1'b0;
    bus_i.err   = man_err;
    if (auto_ack && ack_pend.size() > 0) begin
      bus_i.ack  = 1'b1;
      bus_i.data = ack_pend.pop_front();
    end else begin
      bus_i.ack  = man_ack;
      bus_i.data = 32'hDEAD_BEEF;
    end
    #1;
    last_acc = en_i & ~stall_o;
    s_err = err_o; s_valid = valid_o; s_wack = wack_o; s_stall = stall_o;
    s_cyc = bus_o.cyc; s_stb = bus_o.stb; s_busy = busy_o;
    if (valid_o) n_valid++;
    if (en_i & stall_o) n_stall++;
    if (valid_o & wack_o) chk("both_cpl", 1, 0);
    if (valid_o | wack_o) begin
      cpl_log.push_back(wack_o);
      if (sb.size() == 0) chk("unexpected_cpl", {valid_o, wack_o}, 0);
      else begin
        e = sb.pop_front();
        chk("cpl_kind", wack_o, e.we);
        if (!e.we) chk("rd_data", data_o, e.data);
      end
    end
    if (last_acc) begin
      chk("bus_stb", bus_o.stb, 1);
      chk("bus_addr", bus_o.addr, addr_i);
      chk("bus_we", bus_o.we, we_i);
      e.we = we_i;
      e.data = slave_data(addr_i);
      sb.push_back(e);
      ack_pend.push_back(slave_data(addr_i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [29:0] a);
    bit ok = 0;
    en_i = 1'b1; we_i = we; addr_i = a; data_i = {a, 2'b11}; byte_mask_i = a[3:0];
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_acc) begin ok = 1; break; end
    end
    if (!ok) chk("issue_timeout", 0, 1);
  endtask

  task automatic drain();
    en_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !busy_o) break;
      cycle();
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, first;
    rst = 1'b1; en_i = 0; we_i = 0; data_i = 0; addr_i = 0; byte_mask_i = 0;
    bus_i = '0; man_ack = 0; man_err = 0; auto_ack = 0;
    @(posedge clk); #1;

    // Reset state
    cycle();
    chk("rst_stall", s_stall, 1);
    chk("rst_cyc", s_cyc, 0);
    chk("rst_err", s_err, 0);
    rst = 1'b0;
    cycle();
    chk("post_rst_busy", s_busy, 0);
    chk("post_rst_cyc", s_cyc, 0);

    // Four back-to-back reads, slave acks one cycle later
    auto_ack = 1; n_stall = 0; v0 = n_valid;
    for (int i = 0; i < 4; i++) issue(1'b0, 30'h100 + 30'(i));
    drain();
    chk("t1_valid_cnt", n_valid - v0, 4);
    chk("t1_stall", n_stall, 0);

    // Fill to MAX_OUT with no acks, fifth request stalls
    auto_ack = 0;
    for (int i = 0; i < 4; i++) issue(1'b0, 30'h200 + 30'(i));
    en_i = 1'b1; addr_i = 30'h204;
    cycle();
    chk("t2_stall", s_stall, 1);
    chk("t2_cyc", s_cyc, 1);
    chk("t2_count", dut.count_q, 4);
    cycle();
    chk("t2_cyc_hold", s_cyc, 1);
    auto_ack = 1;
    issue(1'b0, 30'h204);
    drain();

    // Write, read, write completes in order
    cpl_log.delete();
    issue(1'b1, 30'h300);
    issue(1'b0, 30'h301);
    issue(1'b1, 30'h302);
    drain();
    chk("t3_n", cpl_log.size(), 3);
    if (cpl_log.size() == 3) begin
      chk("t3_seq0", cpl_log[0], 1);
      chk("t3_seq1", cpl_log[1], 0);
      chk("t3_seq2", cpl_log[2], 1);
    end

    // Error with two reads outstanding, then a late ack is spurious
    auto_ack = 0;
    issue(1'b0, 30'h400);
    issue(1'b0, 30'h401);
    en_i = 1'b0;
    man_err = 1;
    cycle();
    chk("t4_err", s_err, 1);
    chk("t4_err_valid", s_valid, 0);
    man_err = 0; sb.delete(); ack_pend.delete();
    cycle();
    chk("t4_err_pulse", s_err, 0);
    chk("t4_busy", s_busy, 0);
    chk("t4_cyc", s_cyc, 0);
    cycle();
    man_ack = 1;
    cycle();
    chk("t4_spur_err", s_err, 1);
    chk("t4_spur_valid", s_valid, 0);
    man_ack = 0;
    cycle();
    chk("t4_spur_busy", s_busy, 0);

    // One read never acked
    issue(1'b0, 30'h500);
    en_i = 1'b0; ack_pend.delete();
    first = -1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (s_err && first < 0) first = i;
    end
`ifdef BUS_MASTER_TIMEOUT_EN
    chk("t5_to_cycle", first, TIMEOUT - 1);
    chk("t5_to_busy", busy_o, 0);
`else
    chk("t5_no_timeout", first, -1);
    chk("t5_still_busy", busy_o, 1);
    man_err = 1; cycle(); man_err = 0;
`endif
    sb.delete(); ack_pend.delete();
    cycle();

    // Reset with three outstanding
    issue(1'b0, 30'h600);
    issue(1'b0, 30'h601);
    issue(1'b0, 30'h602);
    en_i = 1'b0;
    chk("t6_pre_count", dut.count_q, 3);
    rst = 1'b1;
    cycle();
    chk("t6_rst_cyc", s_cyc, 0);
    chk("t6_rst_stb", s_stb, 0);
    chk("t6_rst_err", s_err, 0);
    chk("t6_rst_stall", s_stall, 1);
    cycle();
    rst = 1'b0; sb.delete(); ack_pend.delete();
    cycle();
    chk("t6_count", dut.count_q, 0);
    chk("t6_busy", s_busy, 0);
    v0 = n_valid;
    man_ack = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_spur_err", s_err, 1);
    end
    man_ack = 0;
    cycle();
    chk("t6_no_valid", n_valid - v0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master_pipe.md
BUS_MASTER_PIPE -- requirements
Module: bus_master_pipe

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4: maximum outstanding bus requests, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles without ack/err before abort, 2..255.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en_i  in  1  request strobe from client.
REQ-006 SHALL have port we_i  in  1  1=write, 0=read.
REQ-007 SHALL have ports data_i  in  32 (write data); addr_i  in  30 (word address); byte_mask_i  in  4 (byte selects).
REQ-008 SHALL have port data_o  out  32  read data, equal to bus_i.data.
REQ-009 SHALL have ports valid_o  out  1 (read completed); wack_o  out  1 (write completed).
REQ-010 SHALL have ports stall_o  out  1 (request not accepted this cycle); err_o  out  1 (error pulse); busy_o  out  1 (requests outstanding).
REQ-011 SHALL have ports bus_i  in  bus::s2m_s and bus_o  out  bus::m2s_s.

Function
REQ-012 SHALL define full = (count == MAX_OUT); count = number of outstanding requests, width $clog2(MAX_OUT)+1.
REQ-013 SHALL drive bus_o.stb = en_i & ~full & ~rst; bus_o.we = stb & we_i; sel/data/addr pass through from inputs.
REQ-014 SHALL drive bus_o.cyc = bus_o.stb | (count != 0).
REQ-015 SHALL drive stall_o = full | bus_i.stall | bus_i.err | timeout_hit.
REQ-016 SHALL accept a request (push we_i into tracking FIFO) when en_i & ~stall_o; client holds request while stall_o.
REQ-017 SHALL retire the FIFO head on bus_i.ack with count != 0; push and retire in the same cycle leave count unchanged.
REQ-018 SHALL assert valid_o = ack & ~err & (count != 0) & head read; wack_o likewise for head write; never both.
REQ-019 SHALL treat bus_i.ack or bus_i.err with count == 0 as spurious: err_o high one cycle; no state change.
REQ-020 SHALL, on bus_i.err with count != 0, pulse err_o and flush: count <= 0, FIFO pointers <= 0; cyc drops the next cycle unless a new request is accepted.
REQ-021 SHALL respond in order; completions map to requests strictly FIFO.
REQ-022 SHALL drive busy_o = (count != 0).

Reset
REQ-023 SHALL, while rst, clear count, FIFO pointers and timeout counter; stb, cyc, valid_o, wack_o, err_o SHALL be 0; stall_o is 1.
REQ-024 SHALL discard outstanding requests on reset mid-transfer; acks arriving after reset count as spurious (REQ-019).

Configuration
REQ-025 SHALL, with BUS_MASTER_TIMEOUT_EN defined, keep an 8-bit counter cleared on ack/err/accept-from-empty or count==0, incremented otherwise; at TIMEOUT-1 timeout_hit pulses err_o and flushes as REQ-020.
REQ-026 SHALL, without BUS_MASTER_TIMEOUT_EN, contain no counter; timeout_hit is constant 0; waits are unbounded.

Structure
REQ-027 SHALL place MAX_OUT/TIMEOUT default constants and widths in the shared package bus, next to s2m_s/m2s_s.
REQ-028 SHALL implement the tracking FIFO as sub-module bus_track_fifo (1-bit data, depth MAX_OUT, push/pop/flush, head output).

Verification
REQ-029 SHALL test: 4 back-to-back reads, slave acks 1 cycle later each -> 4 valid_o pulses in order, stall_o never high.
REQ-030 SHALL test: MAX_OUT=4, 5 requests with no acks -> 5th sees stall_o=1, cyc stays high, count=4.
REQ-031 SHALL test: write, read, write with acks -> wack_o, valid_o, wack_o in that order.
REQ-032 SHALL test: 2 reads outstanding, bus_i.err -> err_o one cycle, busy_o=0 next cycle, later ack -> spurious err_o.
REQ-033 SHALL test: BUS_MASTER_TIMEOUT_EN, TIMEOUT=16, 1 read never acked -> err_o at cycle 15 after last progress, flush; without macro, no err_o after 100 cycles.
REQ-034 SHALL test: rst asserted with 3 outstanding -> cyc=0 during rst, count=0 after, valid_o never pulses.
